// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
// Sits between the IF/ID pair register and decode of the dual-issue datapath.
// Lane 0 takes ALU/branch ops, lane 1 takes lw/sw. Each cycle the scheduler
// either issues the fetched pair together, splits it over two cycles, or
// inserts load-use bubbles. fetch_hold stops IF/ID while a pair is still
// partly unissued.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ISSUE   | a fresh pair is presented; issue both, the older, or stall
// ST_SPLIT   | older already issued; the younger goes out this cycle
// ST_LU_WAIT | load-use bubbles; r_ret_split picks where to resume
//
// A consumer blocked by a lw costs one detect cycle plus LU_BUBBLES wait
// cycles. The hazard is not re-tested on return because r_lu_vld is cleared
// when LU_WAIT is entered.
module dual_issue_scheduler #(
  parameter int CNT_W      = 32,
  parameter int LU_BUBBLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pair_valid,
  input  logic [31:0]      instr0,
  input  logic [31:0]      instr1,
  input  logic             stall_in,
  input  logic             flush,
  output logic             lane0_valid,
  output logic [31:0]      lane0_instr,
  output logic             lane1_valid,
  output logic [31:0]      lane1_instr,
  output logic             fetch_hold,
  output logic [CNT_W-1:0] dual_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_SPLIT   = 2'd1,
    ST_LU_WAIT = 2'd2
  } state_t;

  function automatic logic f_is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic f_is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // Destination register; 0 means "none" since r0 never creates a hazard.
  function automatic logic [4:0] f_dest(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rd);
    logic [4:0] d;
    case (op)
      OP_RTYPE:      d = rd;
      OP_ADDI, OP_LW: d = rt;
      default:       d = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic f_reads(input logic [5:0] op, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [4:0] r);
    logic hit;
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: hit = (rs == r) || (rt == r);
      OP_ADDI, OP_LW:                  hit = (rs == r);
      default:                         hit = 1'b0;
    endcase
    return hit && (r != 5'd0);
  endfunction

  state_t           r_st;
  logic [4:0]       r_lu_dest;
  logic             r_lu_vld;
  logic [1:0]       r_lu_cnt;
  logic             r_ret_split;
  logic [CNT_W-1:0] r_dual_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  state_t     w_st_nxt;
  logic       w_iss_old;
  logic       w_iss_yng;
  logic       w_hold;
  logic       w_dual_inc;
  logic       w_bub_inc;
  logic [1:0] w_lu_cnt_nxt;
  logic       w_ret_nxt;
  logic       w_lu_vld_nxt;
  logic [4:0] w_lu_dest_nxt;

  logic [5:0] w_op0, w_op1;
  logic [4:0] w_dest0, w_dest1;
  logic       w_mem0, w_mem1;
  logic       w_pairable;
  logic       w_haz_old, w_haz_yng;

  assign w_op0   = instr0[31:26];
  assign w_op1   = instr1[31:26];
  assign w_mem0  = f_is_mem(w_op0);
  assign w_mem1  = f_is_mem(w_op1);
  assign w_dest0 = f_dest(w_op0, instr0[20:16], instr0[15:11]);
  assign w_dest1 = f_dest(w_op1, instr1[20:16], instr1[15:11]);

  assign w_pairable = (w_mem0 != w_mem1)
                   && !f_reads(w_op1, instr1[25:21], instr1[20:16], w_dest0)
                   && !((w_dest0 != 5'd0) && (w_dest0 == w_dest1))
                   && !f_is_branch(w_op1);

  assign w_haz_old = r_lu_vld && f_reads(w_op0, instr0[25:21], instr0[20:16], r_lu_dest);
  assign w_haz_yng = r_lu_vld && f_reads(w_op1, instr1[25:21], instr1[20:16], r_lu_dest);

  // Next-state, issue decision and bookkeeping; flush/stall/reset override last.
  always_comb begin
    w_st_nxt      = r_st;
    w_iss_old     = 1'b0;
    w_iss_yng     = 1'b0;
    w_hold        = 1'b0;
    w_dual_inc    = 1'b0;
    w_bub_inc     = 1'b0;
    w_lu_cnt_nxt  = r_lu_cnt;
    w_ret_nxt     = r_ret_split;
    w_lu_vld_nxt  = r_lu_vld;
    w_lu_dest_nxt = r_lu_dest;

    case (r_st)
      ST_ISSUE: begin
        if (pair_valid) begin
          if (w_haz_old) begin
            w_hold       = 1'b1;
            w_bub_inc    = 1'b1;
            w_lu_cnt_nxt = LU_INIT;
            w_ret_nxt    = 1'b0;
            w_lu_vld_nxt = 1'b0;
            w_st_nxt     = ST_LU_WAIT;
          end else if (w_pairable && !w_haz_yng) begin
            w_iss_old  = 1'b1;
            w_iss_yng  = 1'b1;
            w_dual_inc = 1'b1;
          end else begin
            w_iss_old = 1'b1;
            w_hold    = 1'b1;
            w_st_nxt  = ST_SPLIT;
          end
        end
      end
      ST_SPLIT: begin
        if (w_haz_yng) begin
          w_hold       = 1'b1;
          w_bub_inc    = 1'b1;
          w_lu_cnt_nxt = LU_INIT;
          w_ret_nxt    = 1'b1;
          w_lu_vld_nxt = 1'b0;
          w_st_nxt     = ST_LU_WAIT;
        end else begin
          w_iss_yng = 1'b1;
          w_st_nxt  = ST_ISSUE;
        end
      end
      ST_LU_WAIT: begin
        w_hold    = 1'b1;
        w_bub_inc = 1'b1;
        if (r_lu_cnt == 2'd0) begin
          w_st_nxt = r_ret_split ? ST_SPLIT : ST_ISSUE;
        end else begin
          w_lu_cnt_nxt = r_lu_cnt - 2'd1;
        end
      end
      default: w_st_nxt = ST_ISSUE;
    endcase

    // Any issue retires the old lw tracking; only a lw with rt != 0 re-arms it.
    if (w_iss_old || w_iss_yng) begin
      w_lu_vld_nxt = 1'b0;
      if (w_iss_old && (w_op0 == OP_LW) && (instr0[20:16] != 5'd0)) begin
        w_lu_vld_nxt  = 1'b1;
        w_lu_dest_nxt = instr0[20:16];
      end
      if (w_iss_yng && (w_op1 == OP_LW) && (instr1[20:16] != 5'd0)) begin
        w_lu_vld_nxt  = 1'b1;
        w_lu_dest_nxt = instr1[20:16];
      end
    end

    if (!rst_n) begin
      w_iss_old  = 1'b0;
      w_iss_yng  = 1'b0;
      w_hold     = 1'b0;
      w_dual_inc = 1'b0;
      w_bub_inc  = 1'b0;
    end else if (flush) begin
      w_st_nxt      = ST_ISSUE;
      w_iss_old     = 1'b0;
      w_iss_yng     = 1'b0;
      w_hold        = 1'b0;
      w_dual_inc    = 1'b0;
      w_bub_inc     = 1'b0;
      w_lu_cnt_nxt  = 2'd0;
      w_ret_nxt     = r_ret_split;
      w_lu_vld_nxt  = 1'b0;
      w_lu_dest_nxt = r_lu_dest;
    end else if (stall_in) begin
      w_st_nxt      = r_st;
      w_iss_old     = 1'b0;
      w_iss_yng     = 1'b0;
      w_hold        = 1'b1;
      w_dual_inc    = 1'b0;
      w_bub_inc     = 1'b0;
      w_lu_cnt_nxt  = r_lu_cnt;
      w_ret_nxt     = r_ret_split;
      w_lu_vld_nxt  = r_lu_vld;
      w_lu_dest_nxt = r_lu_dest;
    end
  end

  // Route each issued instruction to its class lane, independent of program order.
  always_comb begin
    lane0_valid = 1'b0;
    lane0_instr = 32'h0;
    lane1_valid = 1'b0;
    lane1_instr = 32'h0;
    if (w_iss_old) begin
      if (w_mem0) begin
        lane1_valid = 1'b1;
        lane1_instr = instr0;
      end else begin
        lane0_valid = 1'b1;
        lane0_instr = instr0;
      end
    end
    if (w_iss_yng) begin
      if (w_mem1) begin
        lane1_valid = 1'b1;
        lane1_instr = instr1;
      end else begin
        lane0_valid = 1'b1;
        lane0_instr = instr1;
      end
    end
  end

  assign fetch_hold = w_hold;
  assign dual_cnt   = r_dual_cnt;
  assign bubble_cnt = r_bubble_cnt;

  // State, load-use tracking and performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st         <= ST_ISSUE;
      r_lu_dest    <= 5'd0;
      r_lu_vld     <= 1'b0;
      r_lu_cnt     <= 2'd0;
      r_ret_split  <= 1'b0;
      r_dual_cnt   <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_st        <= w_st_nxt;
      r_lu_dest   <= w_lu_dest_nxt;
      r_lu_vld    <= w_lu_vld_nxt;
      r_lu_cnt    <= w_lu_cnt_nxt;
      r_ret_split <= w_ret_nxt;
      if (w_dual_inc) r_dual_cnt <= r_dual_cnt + CNT_W'(1);
      if (w_bub_inc)  r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: directed scenarios with
// literal expectations, then randomized traffic against a rule-level model.
module tb_dual_issue_scheduler;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n, pair_valid, stall_in, flush;
  logic [31:0] instr0, instr1;
  logic        lane0_valid, lane1_valid, fetch_hold;
  logic [31:0] lane0_instr, lane1_instr, dual_cnt, bubble_cnt;

  dual_issue_scheduler #(.CNT_W(32), .LU_BUBBLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .pair_valid(pair_valid), .instr0(instr0), .instr1(instr1),
    .stall_in(stall_in), .flush(flush), .lane0_valid(lane0_valid), .lane0_instr(lane0_instr),
    .lane1_valid(lane1_valid), .lane1_instr(lane1_instr), .fetch_hold(fetch_hold),
    .dual_cnt(dual_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_wait = wait cycles left, m_pend = younger still owed,
  // m_load = register written by the last issued lw (0 = none).
  int          m_wait = 0;
  int          m_load = 0;
  bit          m_resume = 0, m_pend = 0, m_known = 0;
  logic [31:0] m_dual = 0, m_bub = 0;
  logic        e_l0v, e_l1v, e_fh = 1'b0;
  logic [31:0] e_l0i, e_l1i;

  function automatic logic [31:0] i_add(int rd, int rs, int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction
  function automatic logic [31:0] i_addi(int rt, int rs, int imm);
    return {6'b001000, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] i_lw(int rt, int off, int rs);
    return {6'b100011, 5'(rs), 5'(rt), 16'(off)};
  endfunction
  function automatic logic [31:0] i_sw(int rt, int off, int rs);
    return {6'b101011, 5'(rs), 5'(rt), 16'(off)};
  endfunction
  function automatic logic [31:0] i_br(bit ne, int rs, int rt);
    return {(ne ? 6'b000101 : 6'b000100), 5'(rs), 5'(rt), 16'h0004};
  endfunction

  function automatic int op_of(logic [31:0] i); return int'(i[31:26]); endfunction
  function automatic int rs_of(logic [31:0] i); return int'(i[25:21]); endfunction
  function automatic int rt_of(logic [31:0] i); return int'(i[20:16]); endfunction

  function automatic bit is_mem(logic [31:0] i);
    return op_of(i) == 35 || op_of(i) == 43;
  endfunction
  function automatic bit is_br(logic [31:0] i);
    return op_of(i) == 4 || op_of(i) == 5;
  endfunction
  function automatic int dst(logic [31:0] i);
    if (op_of(i) == 0) return int'(i[15:11]);
    if (op_of(i) == 8 || op_of(i) == 35) return rt_of(i);
    return 0;
  endfunction
  function automatic bit reads(logic [31:0] i, int r);
    int op = op_of(i);
    if (r == 0) return 0;
    if (op == 0 || op == 4 || op == 5 || op == 43) return rs_of(i) == r || rt_of(i) == r;
    if (op == 8 || op == 35) return rs_of(i) == r;
    return 0;
  endfunction
  function automatic int new_load(logic [31:0] i);
    return (op_of(i) == 35) ? rt_of(i) : 0;
  endfunction
  function automatic bit pairable(logic [31:0] o, logic [31:0] y);
    return (is_mem(o) != is_mem(y)) && !reads(y, dst(o))
        && !(dst(o) != 0 && dst(o) == dst(y)) && !is_br(y);
  endfunction

  function automatic logic [31:0] rand_instr();
    int r1 = int'($urandom_range(0, 5));
    int r2 = int'($urandom_range(0, 5));
    int r3 = int'($urandom_range(0, 5));
    case ($urandom_range(0, 6))
      0: return i_add(r1, r2, r3);
      1: return i_addi(r1, r2, int'($urandom_range(0, 255)));
      2: return i_lw(r1, 4, r2);
      3: return i_sw(r1, 8, r2);
      4: return i_br(1'b0, r1, r2);
      5: return i_br(1'b1, r1, r2);
      default: return 32'h0;
    endcase
  endfunction

  task automatic put(input logic [31:0] i);
    if (is_mem(i)) begin e_l1v = 1'b1; e_l1i = i; end
    else begin e_l0v = 1'b1; e_l0i = i; end
  endtask

  task automatic model_step(input logic pv, input logic [31:0] o, input logic [31:0] y,
                            input logic st, input logic fl, input logic rn);
    e_l0v = 0; e_l1v = 0; e_l0i = 0; e_l1i = 0; e_fh = 0;
    if (!rn) begin
      m_wait = 0; m_pend = 0; m_resume = 0; m_load = 0; m_dual = 0; m_bub = 0; m_known = 1;
    end else if (fl) begin
      m_wait = 0; m_pend = 0; m_load = 0;
    end else if (st) begin
      e_fh = 1;
    end else if (m_wait > 0) begin
      e_fh = 1; m_bub++; m_wait--;
      if (m_wait == 0) m_pend = m_resume;
    end else if (m_pend) begin
      if (reads(y, m_load)) begin
        e_fh = 1; m_bub++; m_wait = L; m_resume = 1; m_load = 0; m_pend = 0;
      end else begin
        put(y); m_pend = 0; m_load = new_load(y);
      end
    end else if (pv) begin
      if (reads(o, m_load)) begin
        e_fh = 1; m_bub++; m_wait = L; m_resume = 0; m_load = 0;
      end else if (pairable(o, y) && !reads(y, m_load)) begin
        put(o); put(y); m_dual++;
        m_load = (new_load(o) != 0) ? new_load(o) : new_load(y);
      end else begin
        put(o); e_fh = 1; m_pend = 1; m_load = new_load(o);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs before the rising edge.
  task automatic cyc(input logic pv, input logic [31:0] a, input logic [31:0] b,
                     input logic st, input logic fl, input logic rn);
    @(negedge clk);
    pair_valid = pv; instr0 = a; instr1 = b; stall_in = st; flush = fl; rst_n = rn;
    #1;
    if (m_known) begin
      chk("dual_cnt", dual_cnt, m_dual);
      chk("bubble_cnt", bubble_cnt, m_bub);
    end
    model_step(pv, a, b, st, fl, rn);
    chk("lane0_valid", lane0_valid, e_l0v);
    chk("lane0_instr", lane0_instr, e_l0i);
    chk("lane1_valid", lane1_valid, e_l1v);
    chk("lane1_instr", lane1_instr, e_l1i);
    chk("fetch_hold", fetch_hold, e_fh);
  endtask

  task automatic do_reset();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, ra, rb;
    logic rpv;
    pair_valid = 0; instr0 = 0; instr1 = 0; stall_in = 0; flush = 0; rst_n = 0;

    // add + lw, independent: dual issue
    do_reset();
    a = i_add(3, 1, 2); b = i_lw(4, 0, 5);
    cyc(1, a, b, 0, 0, 1);
    chk("t1_l0", {lane0_valid, lane0_instr}, {1'b1, a});
    chk("t1_l1", {lane1_valid, lane1_instr}, {1'b1, b});
    chk("t1_fh", fetch_hold, 1'b0);
    settle();
    chk("t1_dual", dual_cnt, 32'd1);

    // RAW inside the pair: split over two cycles
    do_reset();
    a = i_add(3, 1, 2); b = i_lw(4, 0, 3);
    cyc(1, a, b, 0, 0, 1);
    chk("t2_c1", {lane0_valid, lane1_valid, fetch_hold, lane0_instr}, {3'b101, a});
    cyc(1, a, b, 0, 0, 1);
    chk("t2_c2", {lane0_valid, lane1_valid, fetch_hold, lane1_instr}, {3'b010, b});

    // lw then sw clears load tracking, so the add behind needs no bubble
    do_reset();
    a = i_lw(2, 0, 1); b = i_sw(6, 4, 7);
    cyc(1, a, b, 0, 0, 1);
    chk("t3_lw", {lane1_valid, lane1_instr, fetch_hold}, {1'b1, a, 1'b1});
    cyc(1, a, b, 0, 0, 1);
    chk("t3_sw", {lane1_valid, lane1_instr, fetch_hold}, {1'b1, b, 1'b0});
    a = i_add(5, 2, 2); b = 32'h0;
    cyc(1, a, b, 0, 0, 1);
    chk("t3_add", {lane0_valid, lane0_instr}, {1'b1, a});
    cyc(1, a, b, 0, 0, 1);
    chk("t3_nop", {lane0_valid, fetch_hold}, 2'b10);
    settle();
    chk("t3_bub", bubble_cnt, 32'd0);

    // lw + dependent add: detect cycle plus L wait cycles, all bubbles
    do_reset();
    a = i_lw(2, 0, 1); b = i_add(5, 2, 2);
    cyc(1, a, b, 0, 0, 1);
    chk("t4_lw", {lane1_valid, lane1_instr, fetch_hold}, {1'b1, a, 1'b1});
    for (int k = 0; k < L + 1; k++) begin
      cyc(1, a, b, 0, 0, 1);
      chk("t4_bubble", {lane0_valid, lane1_valid, fetch_hold}, 3'b001);
    end
    cyc(1, a, b, 0, 0, 1);
    chk("t4_add", {lane0_valid, lane0_instr, fetch_hold}, {1'b1, b, 1'b0});
    chk("t4_model_bub", m_bub, 32'd3);
    settle();
    chk("t4_bub", bubble_cnt, 32'd3);

    // sw older, addi younger: lanes swapped relative to program order
    do_reset();
    a = i_sw(1, 0, 2); b = i_addi(3, 0, 5);
    cyc(1, a, b, 0, 0, 1);
    chk("t5_l0", {lane0_valid, lane0_instr}, {1'b1, b});
    chk("t5_l1", {lane1_valid, lane1_instr}, {1'b1, a});
    chk("t5_model_dual", m_dual, 32'd1);

    // flush while in SPLIT drops the younger; next pair issues normally
    do_reset();
    a = i_add(3, 1, 2); b = i_lw(4, 0, 3);
    cyc(1, a, b, 0, 0, 1);
    cyc(1, a, b, 0, 1, 1);
    chk("t6_flush", {lane0_valid, lane1_valid, fetch_hold}, 3'b000);
    a = i_add(3, 1, 2); b = i_lw(4, 0, 5);
    cyc(1, a, b, 0, 0, 1);
    chk("t6_next", {lane0_valid, lane1_valid, fetch_hold}, 3'b110);

    // stall in the middle of LU_WAIT freezes the bubble count
    do_reset();
    a = i_lw(2, 0, 1); b = i_add(5, 2, 2);
    cyc(1, a, b, 0, 0, 1);
    cyc(1, a, b, 0, 0, 1);
    cyc(1, a, b, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, a, b, 1, 0, 1);
      chk("t7_stall", {lane0_valid, lane1_valid, fetch_hold}, 3'b001);
    end
    settle();
    chk("t7_bub_frozen", bubble_cnt, 32'd2);
    cyc(1, a, b, 0, 0, 1);
    cyc(1, a, b, 0, 0, 1);
    chk("t7_add", {lane0_valid, lane0_instr}, {1'b1, b});
    settle();
    chk("t7_bub_end", bubble_cnt, 32'd3);

    // reset in LU_WAIT: outputs and counters return to zero
    do_reset();
    a = i_lw(2, 0, 1); b = i_add(5, 2, 2);
    cyc(1, a, b, 0, 0, 1);
    cyc(1, a, b, 0, 0, 1);
    cyc(1, a, b, 0, 0, 0);
    chk("t8_out", {lane0_valid, lane1_valid, fetch_hold, lane0_instr, lane1_instr}, 67'd0);
    settle();
    chk("t8_cnt", {dual_cnt, bubble_cnt}, 64'd0);
    cyc(0, a, b, 0, 0, 1);
    chk("t8_idle", {lane0_valid, lane1_valid, fetch_hold}, 3'b000);

    // randomized traffic; the pair is held whenever the model says fetch is held
    ra = 0; rb = 0; rpv = 0;
    for (int k = 0; k < 4000; k++) begin
      if (!e_fh) begin
        ra = rand_instr(); rb = rand_instr();
        rpv = ($urandom_range(0, 99) < 85);
      end
      cyc(rpv, ra, rb, ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 4),
          !($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
